// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - fetch PC, pipelined imem requests, in-order response FIFO
module inst_fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_fault,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_pc,
    output logic [ILEN-1:0] d_inst,
    output logic            d_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_occ;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_pq_wr;
    logic [AW-1:0]   r_pq_rd;

    // Buffered entries and the PCs of in-flight requests (oldest at r_pq_rd).
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [ILEN-1:0] r_fifo_inst  [DEPTH];
    logic            r_fifo_fault [DEPTH];
    logic [XLEN-1:0] r_pq         [DEPTH];

    logic            w_credit_ok;
    logic            w_accept;
    logic            w_misaligned;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_fault_push;
    logic [CW-1:0]   w_out_next;
    logic            w_fifo_we;
    logic [AW-1:0]   w_fifo_waddr;
    logic [XLEN-1:0] w_fifo_wpc;
    logic [ILEN-1:0] w_fifo_winst;
    logic            w_fifo_wfault;

    // Credit covers both buffered and in-flight words, so the FIFO can never overflow.
    assign w_credit_ok    = ({1'b0, r_occ} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = !reset && (r_state == ST_RUN) && !redirect && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_misaligned   = !reset && redirect && (redirect_pc[1:0] != 2'b00);

    assign w_empty        = (r_occ == '0);
    assign d_valid        = !reset && !w_empty;
    assign w_pop          = d_valid && d_ready && !redirect;

    // A response is kept only when nothing is pending discard and no flush happens now.
    assign w_push         = !reset && imem_rsp_valid && !redirect && (r_drop == '0);
    assign w_fault_push   = w_push && imem_rsp_fault;
    assign w_out_next     = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

    assign d_pc           = d_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign d_inst         = d_valid ? r_fifo_inst[r_rd_ptr]  : '0;
    assign d_fault        = d_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;

    // FIFO write port: a normal response push, or the synthetic misaligned-target fault entry.
    always_comb begin
        w_fifo_we     = 1'b0;
        w_fifo_waddr  = r_wr_ptr;
        w_fifo_wpc    = r_pq[r_pq_rd];
        w_fifo_winst  = imem_rsp_data;
        w_fifo_wfault = imem_rsp_fault;
        if (w_misaligned) begin
            w_fifo_we     = 1'b1;
            w_fifo_waddr  = '0;
            w_fifo_wpc    = redirect_pc;
            w_fifo_winst  = '0;
            w_fifo_wfault = 1'b1;
        end else if (w_push) begin
            w_fifo_we     = 1'b1;
        end
    end

    // Next state: redirect wins; a kept fault response stops fetching.
    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            w_state_next = w_misaligned ? ST_HALT : ST_RUN;
        end else if (w_fault_push) begin
            w_state_next = ST_HALT;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Storage arrays need no reset; validity is carried by the pointers and counters.
    always_ff @(posedge clock) begin
        if (w_fifo_we) begin
            r_fifo_pc[w_fifo_waddr]    <= w_fifo_wpc;
            r_fifo_inst[w_fifo_waddr]  <= w_fifo_winst;
            r_fifo_fault[w_fifo_waddr] <= w_fifo_wfault;
        end
        if (w_accept) begin
            r_pq[r_pq_wr] <= r_pc;
        end
    end

    // Fetch PC, credit counters and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_occ         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pq_wr       <= '0;
            r_pq_rd       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_accept) begin
                r_pq_wr <= r_pq_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                r_pq_rd <= r_pq_rd + AW'(1);
            end
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_pc     <= redirect_pc;
                r_drop   <= w_out_next;
                r_rd_ptr <= '0;
                r_wr_ptr <= w_misaligned ? AW'(1) : '0;
                r_occ    <= w_misaligned ? CW'(1) : '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (w_fault_push) begin
                    r_drop <= w_out_next;
                end else if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Invariants: no response without a request, no push into a full FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && (r_outstanding == '0)));
            assert (!(w_push && !w_pop && (r_occ == CW'(DEPTH))));
        end
    end

endmodule
